sc_mux_scan_controller: RTL and testbench

Sequencer that drives the 4-bit selection input of the 9-channel bus multiplexer and captures the multiplexed bus it returns. It steps through an enabled subset of channels 0..8, waits a programmable settle time after each selection change, and latches one sample per channel. Each sample is presented with a channel tag over a valid/ready handshake to the downstream consumer (register file / ALU operand path).

---
 rtl/sc_mux_scan_controller.sv | 168 ++++++++++++++++
 tb/tb_sc_mux_scan_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_mux_scan_controller.sv
// Mux scan sequencer: walks the enabled channels of a 9-way bus mux, waits a
// programmable settle time after each selection change, and hands each sample on over valid/ready.
module sc_mux_scan_controller #(
    parameter int DATAWIDTH_MUX_SELECTION = 4,
    parameter int DATAWIDTH_BUS           = 8,
    parameter int NUM_CHANNELS            = 9,
    parameter int DATAWIDTH_DWELL         = 4
) (
    input  logic                               SC_MUXSCAN_CLOCK_50,
    input  logic                               SC_MUXSCAN_RESET_InLow,
    input  logic                               SC_MUXSCAN_start_In,
    input  logic                               SC_MUXSCAN_stop_In,
    input  logic                               SC_MUXSCAN_continuous_In,
    input  logic [NUM_CHANNELS-1:0]            SC_MUXSCAN_channelEnable_InBUS,
    input  logic [DATAWIDTH_DWELL-1:0]         SC_MUXSCAN_dwell_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]           SC_MUXSCAN_muxData_InBUS,
    input  logic                               SC_MUXSCAN_ready_In,
    output logic [DATAWIDTH_MUX_SELECTION-1:0] SC_MUXSCAN_selection_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]           SC_MUXSCAN_data_OutBUS,
    output logic [DATAWIDTH_MUX_SELECTION-1:0] SC_MUXSCAN_channel_OutBUS,
    output logic                               SC_MUXSCAN_valid_Out,
    output logic                               SC_MUXSCAN_busy_Out,
    output logic                               SC_MUXSCAN_done_Out
);

    localparam int SW = DATAWIDTH_MUX_SELECTION;
    localparam int DW = DATAWIDTH_DWELL;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t                   state_q;
    logic [SW-1:0]            ptr_q;
    logic [DW-1:0]            cnt_q;
    logic [SW-1:0]            sel_q;
    logic [DATAWIDTH_BUS-1:0] data_q;
    logic [SW-1:0]            chan_q;
    logic                     valid_q;
    logic                     busy_q;
    logic                     done_q;

    logic                     first_found_s;
    logic [SW-1:0]            first_ch_s;
    logic                     next_found_s;
    logic [SW-1:0]            next_ch_s;

    // Returns {found, index} of the lowest enabled channel at or above lo.
    function automatic logic [SW:0] lowest_enabled_from(
        input logic [NUM_CHANNELS-1:0] mask,
        input int                      lo
    );
        logic [SW:0] r;
        r = {(SW+1){1'b0}};
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= lo)) begin
                r = {1'b1, SW'(i)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Channel search on the live mask: first channel for a sweep, and successor of the pointer.
    always_comb begin
        logic [SW:0] first_v;
        logic [SW:0] next_v;
        first_v       = lowest_enabled_from(SC_MUXSCAN_channelEnable_InBUS, 0);
        next_v        = lowest_enabled_from(SC_MUXSCAN_channelEnable_InBUS, int'(ptr_q) + 1);
        first_found_s = first_v[SW];
        first_ch_s    = first_v[SW-1:0];
        next_found_s  = next_v[SW];
        next_ch_s     = next_v[SW-1:0];
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge SC_MUXSCAN_CLOCK_50 or negedge SC_MUXSCAN_RESET_InLow) begin
        if (!SC_MUXSCAN_RESET_InLow) begin
            state_q <= ST_IDLE;
            ptr_q   <= {SW{1'b0}};
            cnt_q   <= {DW{1'b0}};
            sel_q   <= {SW{1'b0}};
            data_q  <= {DATAWIDTH_BUS{1'b0}};
            chan_q  <= {SW{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (SC_MUXSCAN_start_In && !SC_MUXSCAN_stop_In && first_found_s) begin
                        ptr_q   <= first_ch_s;
                        sel_q   <= first_ch_s;
                        cnt_q   <= SC_MUXSCAN_dwell_InBUS;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end else begin
                        sel_q  <= {SW{1'b0}};
                        busy_q <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (SC_MUXSCAN_stop_In) begin
                        state_q <= ST_IDLE;
                        sel_q   <= {SW{1'b0}};
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != {DW{1'b0}}) begin
                        cnt_q <= cnt_q - DW'(1);
                    end else begin
                        data_q  <= SC_MUXSCAN_muxData_InBUS;
                        chan_q  <= ptr_q;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (SC_MUXSCAN_stop_In) begin
                        state_q <= ST_IDLE;
                        sel_q   <= {SW{1'b0}};
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (SC_MUXSCAN_ready_In) begin
                        valid_q <= 1'b0;
                        if (next_found_s) begin
                            ptr_q   <= next_ch_s;
                            sel_q   <= next_ch_s;
                            cnt_q   <= SC_MUXSCAN_dwell_InBUS;
                            state_q <= ST_SETTLE;
                        end else if (SC_MUXSCAN_continuous_In && first_found_s) begin
                            // End of sweep in continuous mode: wrap to the first channel.
                            done_q  <= 1'b1;
                            ptr_q   <= first_ch_s;
                            sel_q   <= first_ch_s;
                            cnt_q   <= SC_MUXSCAN_dwell_InBUS;
                            state_q <= ST_SETTLE;
                        end else begin
                            done_q  <= 1'b1;
                            sel_q   <= {SW{1'b0}};
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sel_q   <= {SW{1'b0}};
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign SC_MUXSCAN_selection_OutBUS = sel_q;
    assign SC_MUXSCAN_data_OutBUS      = data_q;
    assign SC_MUXSCAN_channel_OutBUS   = chan_q;
    assign SC_MUXSCAN_valid_Out        = valid_q;
    assign SC_MUXSCAN_busy_Out         = busy_q;
    assign SC_MUXSCAN_done_Out         = done_q;

endmodule

// File: tb/tb_sc_mux_scan_controller.sv
// Bench for sc_mux_scan_controller: directed scenarios plus randomized sweeps
// checked against a transaction-level model of the expected channel sequence.
module tb_sc_mux_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
    logic [8:0] mask;
    logic [3:0] dwell;
    logic [7:0] mux_data;
    logic       ready;
    logic [3:0] sel;
    logic [7:0] data;
    logic [3:0] chan;
    logic       valid;
    logic       busy;
    logic       done;

    logic [7:0] mux_tab [0:15];
    int vectors    = 0;
    int miscompares = 0;
    int cur_dwell  = 0;
    int dlo        = 0;
    int dhi        = 0;

    always #5 clk = ~clk;

    assign mux_data = mux_tab[sel];

    sc_mux_scan_controller dut (
        .SC_MUXSCAN_CLOCK_50           (clk),
        .SC_MUXSCAN_RESET_InLow        (rst_n),
        .SC_MUXSCAN_start_In           (start),
        .SC_MUXSCAN_stop_In            (stop),
        .SC_MUXSCAN_continuous_In      (cont),
        .SC_MUXSCAN_channelEnable_InBUS(mask),
        .SC_MUXSCAN_dwell_InBUS        (dwell),
        .SC_MUXSCAN_muxData_InBUS      (mux_data),
        .SC_MUXSCAN_ready_In           (ready),
        .SC_MUXSCAN_selection_OutBUS   (sel),
        .SC_MUXSCAN_data_OutBUS        (data),
        .SC_MUXSCAN_channel_OutBUS     (chan),
        .SC_MUXSCAN_valid_Out          (valid),
        .SC_MUXSCAN_busy_Out           (busy),
        .SC_MUXSCAN_done_Out           (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_table(input bit rnd);
        for (int i = 0; i < 16; i++) begin
            mux_tab[i] = rnd ? 8'($urandom) : 8'(8'h10 + i);
        end
    endtask

    // Wait for the capture of exp_ch; dwell is scrambled meanwhile since only its entry value counts.
    task automatic wait_capture(input int exp_ch);
        int n;
        n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
            dwell = 4'($urandom_range(0, 15));
            check("done_quiet", {31'd0, done}, 32'd0);
        end
        check("settle_cycles", n, cur_dwell + 1);
        check("valid_rise", {31'd0, valid}, 32'd1);
        check("cap_channel", {28'd0, chan}, exp_ch);
        check("cap_data", {24'd0, data}, {24'd0, mux_tab[exp_ch]});
        check("sel_at_cap", {28'd0, sel}, exp_ch);
        check("busy_cap", {31'd0, busy}, 32'd1);
    endtask

    // Stall with ready low (stray start pulses must be ignored), then complete the handshake.
    task automatic hold_and_ack(input int exp_ch, input int hold);
        logic [7:0] exp_data;
        exp_data = mux_tab[exp_ch];
        for (int h = 0; h < hold; h++) begin
            start = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            check("hold_valid", {31'd0, valid}, 32'd1);
            check("hold_data", {24'd0, data}, {24'd0, exp_data});
            check("hold_chan", {28'd0, chan}, exp_ch);
            check("hold_sel", {28'd0, sel}, exp_ch);
        end
        dwell     = 4'($urandom_range(dlo, dhi));
        cur_dwell = int'(dwell);
        ready     = 1'b1;
        tick();
        ready = 1'b0;
        check("ack_valid_drop", {31'd0, valid}, 32'd0);
        check("ack_chan_kept", {28'd0, chan}, exp_ch);
        check("ack_data_kept", {24'd0, data}, {24'd0, exp_data});
    endtask

    // Expected sweep order: enabled channels in ascending order.
    task automatic run_sweep(input logic [8:0] m, input bit c, input int rounds, input int hold);
        int q[$];
        q = {};
        for (int i = 0; i < 9; i++) begin
            if (m[i]) q.push_back(i);
        end
        mask      = m;
        cont      = c;
        dwell     = 4'($urandom_range(dlo, dhi));
        cur_dwell = int'(dwell);
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_sel", {28'd0, sel}, q[0]);
        check("start_valid", {31'd0, valid}, 32'd0);
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < q.size(); i++) begin
                wait_capture(q[i]);
                hold_and_ack(q[i], (hold < 0) ? $urandom_range(0, 3) : hold);
                if (i < q.size() - 1) begin
                    check("next_sel", {28'd0, sel}, q[i+1]);
                    check("mid_done", {31'd0, done}, 32'd0);
                    check("mid_busy", {31'd0, busy}, 32'd1);
                end else begin
                    check("done_pulse", {31'd0, done}, 32'd1);
                    if (c) begin
                        check("wrap_sel", {28'd0, sel}, q[0]);
                        check("wrap_busy", {31'd0, busy}, 32'd1);
                    end else begin
                        check("end_sel", {28'd0, sel}, 32'd0);
                        check("end_busy", {31'd0, busy}, 32'd0);
                        tick();
                        check("done_one_cycle", {31'd0, done}, 32'd0);
                        check("idle_busy", {31'd0, busy}, 32'd0);
                    end
                end
            end
        end
    endtask

    task automatic stop_now();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", {31'd0, busy}, 32'd0);
        check("stop_valid", {31'd0, valid}, 32'd0);
        check("stop_done", {31'd0, done}, 32'd0);
        check("stop_sel", {28'd0, sel}, 32'd0);
        tick();
        check("stop_no_done", {31'd0, done}, 32'd0);
        check("stop_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cont  = 1'b0;
        mask  = 9'h000;
        dwell = 4'd0;
        ready = 1'b0;
        fill_table(1'b0);
        tick();
        tick();
        check("rst_sel", {28'd0, sel}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Full mask, zero dwell, no stalls: samples two cycles apart.
        dlo = 0; dhi = 0;
        run_sweep(9'h1FF, 1'b0, 1, 0);

        // Sparse mask with dwell 3 and five stall cycles per sample.
        dlo = 3; dhi = 3;
        run_sweep(9'h0A4, 1'b0, 1, 5);

        // Continuous sweep, then stop while settling on channel 8.
        run_sweep(9'h101, 1'b1, 2, 1);
        wait_capture(0);
        hold_and_ack(0, 0);
        check("cont_sel8", {28'd0, sel}, 32'd8);
        stop_now();

        // Start with an empty mask is ignored.
        mask  = 9'h000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_busy", {31'd0, busy}, 32'd0);
        check("empty_done", {31'd0, done}, 32'd0);
        tick();
        check("empty_done2", {31'd0, done}, 32'd0);
        check("empty_sel", {28'd0, sel}, 32'd0);

        // Asynchronous reset while a sample is held.
        dlo = 1; dhi = 1;
        mask      = 9'h1FF;
        cont      = 1'b0;
        dwell     = 4'd1;
        cur_dwell = 1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_capture(0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_sel", {28'd0, sel}, 32'd0);
        check("arst_data", {24'd0, data}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_sel", {28'd0, sel}, 32'd0);

        // Randomized sweeps.
        dlo = 0; dhi = 5;
        for (int t = 0; t < 12; t++) begin
            bit c;
            fill_table(1'b1);
            c = 1'($urandom_range(0, 1));
            run_sweep(9'($urandom_range(1, 511)), c, c ? 2 : 1, -1);
            if (c) begin
                stop_now();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
